bus_ram: RTL and testbench

- Parametrised successor to the single-port data RAM on the shared 32-bit tri-state CPU bus.
- Adds configurable width, depth and read latency, byte-enable stores, and a ready handshake toward the control unit.
- Adds a hardware zero-fill sequence after reset and an error flag for illegal or out-of-range requests.
- Sits between the control unit (addr, RAM_read, RAM_write) and the shared bus, replacing the fixed 1024x32 RAM.

---
 rtl/bus_ram.sv | 139 +++++++++++++
 tb/tb_bus_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram.sv
// bus_ram: parametrised single-port data RAM on the shared tri-state CPU bus.
// Byte-enable stores, configurable read latency, ready handshake, optional
// zero-fill after reset and a one-cycle error pulse for bad requests.
module bus_ram #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  RAM_read,
  input  logic                  RAM_write,
  input  logic [DATA_W/8-1:0]   byte_en,
  inout  logic [DATA_W-1:0]     bus,
  output logic                  ready,
  output logic                  rdata_valid,
  output logic                  err,
  output logic                  init_done
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W  = $clog2(READ_LAT + 1);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_FILL = DEPTH_L - 1'b1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 2);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, DRIVE} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? INIT : IDLE;

  state_t              state, state_d;
  logic [ADDR_W:0]     fill_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [IDX_W-1:0]    addr_q;
  logic                oor_q;
  logic                err_d;
  logic                fill_we;
  logic                store_we;
  logic                load_acc;
  logic                in_range;
  logic [DATA_W-1:0]   rdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign in_range = ({1'b0, addr} < DEPTH_L);

  // Next-state and request decode; requests only count in IDLE
  always_comb begin
    state_d  = state;
    err_d    = 1'b0;
    fill_we  = 1'b0;
    store_we = 1'b0;
    load_acc = 1'b0;
    case (state)
      INIT: begin
        fill_we = 1'b1;
        if (fill_cnt == LAST_FILL) state_d = IDLE;
      end
      IDLE: begin
        if (RAM_read && RAM_write) begin
          err_d = 1'b1;
        end else if (RAM_read) begin
          if (in_range) store_we = 1'b1;
          else          err_d    = 1'b1;
        end else if (RAM_write) begin
          load_acc = 1'b1;
          err_d    = ~in_range;
          state_d  = (READ_LAT > 1) ? WAIT : DRIVE;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        state_d = IDLE;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_d;
  end

  // Fill counter, latency counter, latched load address and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      lat_cnt  <= '0;
      addr_q   <= '0;
      oor_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err_d;
      if (fill_we) fill_cnt <= fill_cnt + 1'b1;
      if (load_acc) begin
        addr_q  <= addr[IDX_W-1:0];
        oor_q   <= ~in_range;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  // Memory array: zero-fill during INIT, byte-masked stores in IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        mem[fill_cnt[IDX_W-1:0]] <= '0;
      end else if (store_we) begin
        for (int unsigned i = 0; i < MASK_W; i++) begin
          if (byte_en[i]) mem[addr[IDX_W-1:0]][8*i +: 8] <= bus[8*i +: 8];
        end
      end
    end
  end

  // Read path: no store can land between acceptance and DRIVE, so reading
  // at DRIVE time returns the same word as reading at acceptance.
  always_comb begin
    rdata = '0;
    if (!oor_q) rdata = mem[addr_q];
  end

  assign bus         = (state == DRIVE) ? rdata : 'z;
  assign ready       = (state == IDLE);
  assign rdata_valid = (state == DRIVE);
  assign init_done   = (state != INIT);

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: randomized self-checking bench for bus_ram. Two instances
// (read latency 1 and 3) share the request inputs; a word-array model
// predicts load data, error pulses and handshake timing.
module tb_bus_ram;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [NB-1:0] be;
  logic          tb_drv;
  logic [DW-1:0] tb_data;

  wire  [DW-1:0] bus1;
  wire  [DW-1:0] bus3;
  assign bus1 = tb_drv ? tb_data : 'z;
  assign bus3 = tb_drv ? tb_data : 'z;

  logic ready1, valid1, err1, done1;
  logic ready3, valid3, err3, done3;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  bus_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RST(1)) u_lat1 (
    .clk(clk), .rst(rst), .addr(addr), .RAM_read(rd), .RAM_write(wr), .byte_en(be),
    .bus(bus1), .ready(ready1), .rdata_valid(valid1), .err(err1), .init_done(done1)
  );

  bus_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(3), .CLEAR_ON_RST(1)) u_lat3 (
    .clk(clk), .rst(rst), .addr(addr), .RAM_read(rd), .RAM_write(wr), .byte_en(be),
    .bus(bus3), .ready(ready3), .rdata_valid(valid3), .err(err3), .init_done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready1 && ready3) && n < 200) begin
      step();
      n++;
    end
    if (!(ready1 && ready3)) check("ready_timeout", 32'(ready1 && ready3), 32'd1);
  endtask

  // Called with rst already high: applies the reset edge, then follows the fill
  // while a store request is held (it must be ignored in INIT).
  task automatic fill_check();
    step();
    rst     = 1'b0;
    rd      = 1'b1;
    wr      = 1'b0;
    addr    = AW'(0);
    be      = '1;
    tb_drv  = 1'b1;
    tb_data = 32'hFFFF_FFFF;
    for (int i = 0; i <= DEPTH; i++) begin
      check("fill_ready1", 32'(ready1), 32'(i >= DEPTH));
      check("fill_ready3", 32'(ready3), 32'(i >= DEPTH));
      check("fill_done1",  32'(done1),  32'(i >= DEPTH));
      check("fill_done3",  32'(done3),  32'(i >= DEPTH));
      check("fill_valid",  32'(valid1 | valid3), 32'd0);
      check("fill_err",    32'(err1 | err3), 32'd0);
      if (i == DEPTH - 1) begin
        rd     = 1'b0;
        tb_drv = 1'b0;
      end
      if (i < DEPTH) step();
    end
    for (int j = 0; j < DEPTH; j++) ref_mem[j] = '0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [NB-1:0] m);
    wait_ready();
    addr    = a;
    rd      = 1'b1;
    wr      = 1'b0;
    be      = m;
    tb_drv  = 1'b1;
    tb_data = d;
    step();
    rd     = 1'b0;
    tb_drv = 1'b0;
    check("store_err1", 32'(err1), 32'(a >= DEPTH));
    check("store_err3", 32'(err3), 32'(a >= DEPTH));
    if (a < DEPTH)
      for (int i = 0; i < NB; i++)
        if (m[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic pulse);
    logic [31:0] exp;
    logic        exp_err;
    wait_ready();
    exp     = (a < DEPTH) ? ref_mem[a] : 32'h0;
    exp_err = (a >= DEPTH);
    addr    = a;
    rd      = 1'b0;
    wr      = 1'b1;
    step();
    wr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("ld_valid1", 32'(valid1), 32'(k == 1));
      check("ld_valid3", 32'(valid3), 32'(k == 3));
      check("ld_ready1", 32'(ready1), 32'(k >= 2));
      check("ld_ready3", 32'(ready3), 32'(k >= 4));
      check("ld_err1",   32'(err1),   32'((k == 1) ? exp_err : 1'b0));
      check("ld_err3",   32'(err3),   32'((k == 1) ? exp_err : 1'b0));
      if (k == 1) check("ld_data1", bus1, exp);
      if (k == 3) check("ld_data3", bus3, exp);
      if (pulse && k == 1) begin
        wr   = 1'b1;
        addr = a ^ AW'(1);
      end else begin
        wr = 1'b0;
      end
      step();
    end
    wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    rd = 1'b0; wr = 1'b0; addr = '0; be = '0; tb_drv = 1'b0; tb_data = '0;
    rst = 1'b1;
    step();
    fill_check();

    // freshly filled memory reads all zeros
    for (int a = 0; a < DEPTH; a++) do_load(AW'(a), 1'b0);

    // full-word store then load; masked merge; load with ignored request
    do_store(AW'(5), 32'hDEAD_BEEF, 4'hF);
    do_load(AW'(5), 1'b0);
    do_store(AW'(5), 32'h1122_3344, 4'b0101);
    do_load(AW'(5), 1'b1);
    do_store(AW'(5), 32'hAAAA_AAAA, 4'h0);
    do_load(AW'(5), 1'b0);

    // simultaneous read and write: nothing accepted, error next cycle
    do_store(AW'(3), 32'h0BAD_F00D, 4'hF);
    wait_ready();
    addr = AW'(3); rd = 1'b1; wr = 1'b1; be = '1; tb_drv = 1'b1; tb_data = 32'h5555_5555;
    step();
    rd = 1'b0; wr = 1'b0; tb_drv = 1'b0;
    check("both_err1", 32'(err1), 32'd1);
    check("both_err3", 32'(err3), 32'd1);
    check("both_idle", 32'(ready1 & ready3), 32'd1);
    step();
    check("both_err_clr", 32'(err1 | err3), 32'd0);
    do_load(AW'(3), 1'b0);

    // out-of-range store and load
    do_store(AW'(20), 32'h1234_5678, 4'hF);
    do_load(AW'(20), 1'b0);
    do_load(AW'(4), 1'b0);

    // randomized traffic including back-to-back stores and out-of-range hits
    for (int n = 0; n < 80; n++) begin
      ra = AW'($urandom_range(0, DEPTH + 3));
      if ($urandom_range(0, 9) < 5) do_store(ra, $urandom, NB'($urandom));
      else                          do_load(ra, 1'($urandom));
    end
    for (int a = 0; a < DEPTH; a++) do_load(AW'(a), 1'b0);

    // reset during the fill restarts it
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    fill_check();
    do_store(AW'(2), 32'hCAFE_0002, 4'hF);
    do_load(AW'(2), 1'b0);

    // reset while the latency-3 instance is waiting: its load is dropped
    wait_ready();
    addr = AW'(2); wr = 1'b1;
    step();
    wr  = 1'b0;
    rst = 1'b1;
    fill_check();
    do_load(AW'(2), 1'b0);
    do_load(AW'(9), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
